// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: EX gets zero-latency pass-through, DMA bursts fill idle slots.
// Define DMEM_ARB_STARVE_EN to let a starved DMA burst pre-empt EX after STARVE_LIMIT slots.
module dmem_arbiter #(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned DMEM_WORD_WIDTH = 16,
  parameter int unsigned LEN_WIDTH       = 4,
  parameter int unsigned ADDR_STEP       = 1,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_ex_load,
  input  logic                       in_ex_store,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_ex_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_ex_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_ex_wr_word,
  output logic                       out_stall_ex,
  input  logic                       in_dma_req,
  input  logic                       in_dma_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dma_addr,
  input  logic [LEN_WIDTH-1:0]       in_dma_len,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dma_wdata,
  output logic                       out_dma_beat,
  output logic                       out_dma_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] out_dma_rdata,
  output logic                       out_dma_done,
  output logic                       out_dmem_rd_en,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
  output logic                       out_dmem_wr_en,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                     state_q;
  logic                       we_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]       left_q;
  logic                       rvalid_q;

  logic ex_req;
  logic preempt;
  logic dma_slot;

`ifdef DMEM_ARB_STARVE_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  logic [StarveW-1:0] starve_q;
  assign preempt = (state_q == StBurst) && (starve_q == StarveW'(STARVE_LIMIT));
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign preempt = 1'b0;
`endif

  assign ex_req   = in_ex_load | in_ex_store;
  assign dma_slot = (state_q == StBurst) && (!ex_req || preempt);

  // Outputs are combinational (EX pass-through) so they are forced low while reset is held.
  always_comb begin
    out_stall_ex     = 1'b0;
    out_dma_beat     = 1'b0;
    out_dma_done     = 1'b0;
    out_dma_rvalid   = 1'b0;
    out_dma_rdata    = '0;
    out_dmem_rd_en   = 1'b0;
    out_dmem_rd_addr = '0;
    out_dmem_wr_en   = 1'b0;
    out_dmem_wr_addr = '0;
    out_dmem_wr_word = '0;
    if (reset) begin
      out_stall_ex   = ex_req & preempt;
      out_dma_beat   = dma_slot;
      out_dma_done   = dma_slot && (left_q == '0);
      out_dma_rvalid = rvalid_q;
      out_dma_rdata  = rvalid_q ? in_dmem_rd_word : '0;
      if (dma_slot) begin
        out_dmem_rd_en   = ~we_q;
        out_dmem_rd_addr = addr_q;
        out_dmem_wr_en   = we_q;
        out_dmem_wr_addr = addr_q;
        out_dmem_wr_word = in_dma_wdata;
      end else begin
        out_dmem_rd_en   = in_ex_load;
        out_dmem_rd_addr = in_ex_rd_addr;
        out_dmem_wr_en   = in_ex_store;
        out_dmem_wr_addr = in_ex_wr_addr;
        out_dmem_wr_word = in_ex_wr_word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      left_q   <= '0;
      rvalid_q <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      starve_q <= '0;
`endif
    end else begin
      rvalid_q <= dma_slot & ~we_q;
      case (state_q)
        StIdle: begin
`ifdef DMEM_ARB_STARVE_EN
          starve_q <= '0;
`endif
          if (in_dma_req) begin
            we_q    <= in_dma_we;
            addr_q  <= in_dma_addr;
            left_q  <= in_dma_len;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (dma_slot) begin
            addr_q <= addr_q + DMEM_ADDR_WIDTH'(ADDR_STEP);
            left_q <= left_q - LEN_WIDTH'(1);
`ifdef DMEM_ARB_STARVE_EN
            starve_q <= '0;
`endif
            if (left_q == '0) state_q <= StIdle;
          end
`ifdef DMEM_ARB_STARVE_EN
          else if (starve_q != StarveW'(STARVE_LIMIT)) begin
            starve_q <= starve_q + StarveW'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected DMA beats/read data are queued at request time
// and retired by a negedge monitor; EX pass-through and reset behaviour are checked inline.
module tb_dmem_arbiter;

  typedef struct packed {
    logic [11:0] addr;
    logic        we;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_ex_load, in_ex_store;
  logic [11:0] in_ex_rd_addr, in_ex_wr_addr;
  logic [15:0] in_ex_wr_word;
  logic        out_stall_ex;
  logic        in_dma_req, in_dma_we;
  logic [11:0] in_dma_addr;
  logic [3:0]  in_dma_len;
  logic [15:0] in_dma_wdata;
  logic        out_dma_beat, out_dma_rvalid, out_dma_done;
  logic [15:0] out_dma_rdata;
  logic        out_dmem_rd_en, out_dmem_wr_en;
  logic [11:0] out_dmem_rd_addr, out_dmem_wr_addr;
  logic [15:0] out_dmem_wr_word;
  logic [15:0] in_dmem_rd_word;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  logic [15:0] rd_q[$];
  logic        exp_rvalid = 1'b0;
  logic [15:0] pending_rd = 16'h0;

  dmem_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .in_ex_load       (in_ex_load),
    .in_ex_store      (in_ex_store),
    .in_ex_rd_addr    (in_ex_rd_addr),
    .in_ex_wr_addr    (in_ex_wr_addr),
    .in_ex_wr_word    (in_ex_wr_word),
    .out_stall_ex     (out_stall_ex),
    .in_dma_req       (in_dma_req),
    .in_dma_we        (in_dma_we),
    .in_dma_addr      (in_dma_addr),
    .in_dma_len       (in_dma_len),
    .in_dma_wdata     (in_dma_wdata),
    .out_dma_beat     (out_dma_beat),
    .out_dma_rvalid   (out_dma_rvalid),
    .out_dma_rdata    (out_dma_rdata),
    .out_dma_done     (out_dma_done),
    .out_dmem_rd_en   (out_dmem_rd_en),
    .out_dmem_rd_addr (out_dmem_rd_addr),
    .out_dmem_wr_en   (out_dmem_wr_en),
    .out_dmem_wr_addr (out_dmem_wr_addr),
    .out_dmem_wr_word (out_dmem_wr_word),
    .in_dmem_rd_word  (in_dmem_rd_word)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; memory data and DMA write data follow.
  task automatic next();
    @(posedge clock);
    #1;
    in_dmem_rd_word = pending_rd;
    in_dma_wdata    = (exp_q.size() != 0) ? {4'hD, exp_q[0].addr} : 16'h0;
  endtask

  // Monitor: retires expected beats and read data.
  always @(negedge clock) begin
    beat_t e;
    if (out_dma_rvalid || exp_rvalid) begin
      check_eq("rvalid", 32'(out_dma_rvalid), 32'(exp_rvalid));
      if (exp_rvalid) begin
        if (rd_q.size() == 0) check_eq("rdata_unexpected", 32'(1), 32'(0));
        else check_eq("rdata", 32'(out_dma_rdata), 32'(rd_q.pop_front()));
      end
    end else begin
      check_eq("rdata_idle_zero", 32'(out_dma_rdata), 32'(0));
    end
    exp_rvalid = 1'b0;
    if (out_dma_beat) begin
      if (exp_q.size() == 0) begin
        check_eq("beat_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("beat_wr_en", 32'(out_dmem_wr_en), 32'(e.we));
        check_eq("beat_rd_en", 32'(out_dmem_rd_en), 32'(!e.we));
        check_eq("beat_addr", 32'(e.we ? out_dmem_wr_addr : out_dmem_rd_addr), 32'(e.addr));
        if (e.we) check_eq("beat_wr_word", 32'(out_dmem_wr_word), 32'({4'hD, e.addr}));
        check_eq("beat_done", 32'(out_dma_done), 32'(e.last));
        exp_rvalid = !e.we;
      end
    end else if (out_dma_done) begin
      check_eq("done_without_beat", 32'(1), 32'(0));
    end
    pending_rd = {4'hA, out_dmem_rd_addr};
  end

  task automatic start_burst(input logic we, input logic [11:0] base, input logic [3:0] len);
    beat_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.addr = base + 12'(i);
      e.we   = we;
      e.last = (i == int'(len));
      exp_q.push_back(e);
      if (!we) rd_q.push_back({4'hA, e.addr});
    end
    in_dma_req  = 1'b1;
    in_dma_we   = we;
    in_dma_addr = base;
    in_dma_len  = len;
    @(negedge clock);
    check_eq("latch_no_beat", 32'(out_dma_beat), 32'(0));
    next();
  endtask

  task automatic run_until_done(input int budget, output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clock);
      n++;
      if (out_dma_done) seen = 1'b1;
      else next();
    end
    if (!seen) check_eq("done_timeout", 32'(0), 32'(1));
    in_dma_req = 1'b0;
    next();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 32'(out_stall_ex), 32'(0));
    check_eq({tag, "_beat"}, 32'(out_dma_beat), 32'(0));
    check_eq({tag, "_done"}, 32'(out_dma_done), 32'(0));
    check_eq({tag, "_rvalid"}, 32'(out_dma_rvalid), 32'(0));
    check_eq({tag, "_rd_en"}, 32'(out_dmem_rd_en), 32'(0));
    check_eq({tag, "_rd_addr"}, 32'(out_dmem_rd_addr), 32'(0));
    check_eq({tag, "_wr_en"}, 32'(out_dmem_wr_en), 32'(0));
    check_eq({tag, "_wr_addr"}, 32'(out_dmem_wr_addr), 32'(0));
    check_eq({tag, "_wr_word"}, 32'(out_dmem_wr_word), 32'(0));
  endtask

  initial begin
    int n;
    int k;
    bit exp_beat;
    reset           = 1'b0;
    in_ex_load      = 1'b1;
    in_ex_store     = 1'b1;
    in_ex_rd_addr   = 12'h123;
    in_ex_wr_addr   = 12'h456;
    in_ex_wr_word   = 16'h789A;
    in_dma_req      = 1'b1;
    in_dma_we       = 1'b1;
    in_dma_addr     = 12'h0AA;
    in_dma_len      = 4'h2;
    in_dma_wdata    = 16'h0;
    in_dmem_rd_word = 16'hFFFF;

    // Outputs held low during reset even with live requests.
    repeat (2) next();
    @(negedge clock);
    check_all_zero("rst");
    next();
    reset       = 1'b1;
    in_dma_req  = 1'b0;
    in_ex_store = 1'b0;
    in_ex_load  = 1'b1;
    in_ex_rd_addr = 12'h010;

    // EX load pass-through.
    @(negedge clock);
    check_eq("ex_ld_rd_en", 32'(out_dmem_rd_en), 32'(1));
    check_eq("ex_ld_rd_addr", 32'(out_dmem_rd_addr), 32'h010);
    check_eq("ex_ld_stall", 32'(out_stall_ex), 32'(0));
    check_eq("ex_ld_wr_en", 32'(out_dmem_wr_en), 32'(0));
    next();
    in_ex_store   = 1'b1;
    in_ex_rd_addr = 12'h020;
    in_ex_wr_addr = 12'h030;
    in_ex_wr_word = 16'hBEEF;
    @(negedge clock);
    check_eq("ex_ldst_rd_en", 32'(out_dmem_rd_en), 32'(1));
    check_eq("ex_ldst_rd_addr", 32'(out_dmem_rd_addr), 32'h020);
    check_eq("ex_ldst_wr_en", 32'(out_dmem_wr_en), 32'(1));
    check_eq("ex_ldst_wr_addr", 32'(out_dmem_wr_addr), 32'h030);
    check_eq("ex_ldst_wr_word", 32'(out_dmem_wr_word), 32'hBEEF);
    next();
    in_ex_load  = 1'b0;
    in_ex_store = 1'b0;
    @(negedge clock);
    check_eq("ex_idle_rd_en", 32'(out_dmem_rd_en), 32'(0));
    check_eq("ex_idle_wr_en", 32'(out_dmem_wr_en), 32'(0));
    check_eq("ex_idle_stall", 32'(out_stall_ex), 32'(0));
    next();

    // Write burst, EX idle: four back-to-back beats.
    start_burst(1'b1, 12'h100, 4'd3);
    run_until_done(20, n);
    check_eq("wr_burst_cycles", 32'(n), 32'(4));

    // Read burst across the address wrap.
    start_burst(1'b0, 12'hFFF, 4'd1);
    run_until_done(20, n);
    check_eq("rd_wrap_cycles", 32'(n), 32'(2));
    next();

    // EX stores every cycle during a 2-beat read burst.
    start_burst(1'b0, 12'h200, 4'd1);
    for (int i = 0; i < 18; i++) begin
      in_ex_store   = 1'b1;
      in_ex_wr_addr = 12'h040 + 12'(i);
      in_ex_wr_word = 16'h1000 + 16'(i);
`ifdef DMEM_ARB_STARVE_EN
      exp_beat = (i == 8) || (i == 17);
`else
      exp_beat = 1'b0;
`endif
      @(negedge clock);
      check_eq("busy_beat", 32'(out_dma_beat), 32'(exp_beat));
      check_eq("busy_stall", 32'(out_stall_ex), 32'(exp_beat));
      check_eq("busy_wr_en", 32'(out_dmem_wr_en), 32'(!exp_beat));
      if (!exp_beat) check_eq("busy_wr_addr", 32'(out_dmem_wr_addr), 32'(12'h040 + 12'(i)));
      if (out_dma_done) in_dma_req = 1'b0;
      next();
    end
    in_ex_store = 1'b0;
`ifndef DMEM_ARB_STARVE_EN
    run_until_done(10, n);
    check_eq("resume_cycles", 32'(n), 32'(2));
`else
    in_dma_req = 1'b0;
    @(negedge clock);
    check_eq("starve_after_beat", 32'(out_dma_beat), 32'(0));
    next();
`endif
    next();

    // Reset after beat 2 of 4: burst abandoned, restart from base.
    start_burst(1'b1, 12'h300, 4'd3);
    k = 0;
    n = 0;
    while (k < 2 && n < 10) begin
      @(negedge clock);
      if (out_dma_beat) k++;
      n++;
      next();
    end
    check_eq("mid_beats_seen", 32'(k), 32'(2));
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("mid_rst");
    next();
    reset      = 1'b1;
    in_dma_req = 1'b0;
    @(negedge clock);
    check_eq("post_rst_beat", 32'(out_dma_beat), 32'(0));
    check_eq("abandoned_beats", 32'(exp_q.size()), 32'(2));
    exp_q.delete();
    next();
    start_burst(1'b1, 12'h300, 4'd3);
    run_until_done(20, n);
    check_eq("restart_cycles", 32'(n), 32'(4));

    repeat (3) next();
    check_eq("beat_q_empty", 32'(exp_q.size()), 32'(0));
    check_eq("rd_q_empty", 32'(rd_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
